// File: rtl/ram_stream_reader_pkg.sv
// Shared types for the RAM stream reader: controller state encoding.
package ram_stream_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/ram_stream_reader_sync_fifo.sv
// Small synchronous FIFO; head shows the oldest entry, simultaneous push and pop keep the count.
module sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic [DATA_WIDTH-1:0]       push_data,
   input  logic                        pop,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic [DATA_WIDTH-1:0]       head,
   output logic                        empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]        count_q, count_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);

endmodule

// File: rtl/ram_stream_reader.sv
// Sweeps a run of RAM words and streams them out over valid/ready, absorbing the 1-cycle read latency.
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [ADDRESS_WIDTH:0]   length,
   output logic                     busy,
   output logic                     done,
   output logic                     ram_wEn,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0]    ram_dataOut,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    out_data,
   input  logic                     out_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(FIFO_DEPTH);

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
   logic                     rd_issued_q, rd_issued_d;
   logic                     inflight_q, inflight_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic [CNT_W-1:0]         fifo_count;
   logic [DATA_WIDTH-1:0]    fifo_head;
   logic                     fifo_empty;
   logic                     pop;
   logic [CNT_W:0]           occupancy;
   logic                     issue_ok;

   // Reads sitting in the address stage and the data stage both hold a FIFO slot.
   assign pop       = !fifo_empty && out_ready;
   assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_issued_q}
                    + {{CNT_W{1'b0}}, inflight_q};
   assign issue_ok  = occupancy < DEPTH_LIM;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      rd_issued_d = 1'b0;
      inflight_d  = rd_issued_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length == '0) begin
                  done_d = 1'b1;
               end else begin
                  // The first address goes out on the start edge itself.
                  addr_d      = base_addr;
                  rd_issued_d = 1'b1;
                  remaining_d = length - (ADDRESS_WIDTH+1)'(1);
                  busy_d      = 1'b1;
                  state_d     = (length == (ADDRESS_WIDTH+1)'(1)) ? ST_DRAIN : ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (issue_ok) begin
               addr_d      = addr_q + ADDRESS_WIDTH'(1);
               rd_issued_d = 1'b1;
               remaining_d = remaining_q - (ADDRESS_WIDTH+1)'(1);
               if (remaining_q == (ADDRESS_WIDTH+1)'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!rd_issued_q && !inflight_q && pop && fifo_count == CNT_W'(1)) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         rd_issued_q <= 1'b0;
         inflight_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         rd_issued_q <= rd_issued_d;
         inflight_q  <= inflight_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (ram_dataOut),
      .pop       (pop),
      .count     (fifo_count),
      .head      (fifo_head),
      .empty     (fifo_empty)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign ram_wEn   = 1'b0;
   assign ram_addr  = addr_q;
   assign out_valid = !fifo_empty;
   assign out_data  = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: preloaded RAM model, random backpressure, queue-based expected stream.
module tb_ram_stream_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] base_addr = '0;
   logic [12:0] length = '0;
   logic        busy, done, ram_wEn;
   logic [11:0] ram_addr;
   logic [31:0] ram_dataOut;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready = 1'b1;

   ram_stream_reader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .length      (length),
      .busy        (busy),
      .done        (done),
      .ram_wEn     (ram_wEn),
      .ram_addr    (ram_addr),
      .ram_dataOut (ram_dataOut),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready)
   );

   always #5 clk = ~clk;

   logic [31:0] ram_mem [4096];
   initial for (int i = 0; i < 4096; i++) ram_mem[i] = i + 32'h100;
   always @(posedge clk) if (!ram_wEn) ram_dataOut <= ram_mem[ram_addr];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   logic [31:0] exp_q[$];
   logic [11:0] addr_log[$];
   int          cyc = 0;
   int          hs_count = 0, hs_first = 0, hs_last = 0, done_cnt = 0, fifo_max = 0;
   bit          rand_ready = 0;
   bit          stall_prev = 0;
   logic [31:0] data_prev = '0;
   logic [11:0] addr_prev = '0;

   always @(posedge clk) cyc++;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? ($urandom_range(0, 3) == 0) : 1'b1;
      end
   end

   // Stream monitor: handshakes (taken at the next rising edge), stall stability, done and address trace.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 0;
         addr_prev  = '0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, data_prev);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_word_queue", exp_q.size(), 1);
            else check("word", out_data, exp_q.pop_front());
            hs_count++;
            if (hs_count == 1) hs_first = cyc;
            hs_last = cyc;
         end
         stall_prev = out_valid && !out_ready;
         data_prev  = out_data;
         if (done) done_cnt++;
         if (ram_addr != addr_prev) begin
            addr_log.push_back(ram_addr);
            addr_prev = ram_addr;
         end
         if (int'(dut.u_fifo.count) > fifo_max) fifo_max = int'(dut.u_fifo.count);
      end
   end

   task automatic start_xfer(input logic [11:0] b, input logic [12:0] n, input bit expect_words);
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = b;
      length    = n;
      if (expect_words) begin
         hs_count = 0;
         done_cnt = 0;
         addr_log.delete();
         for (int i = 0; i < int'(n); i++) begin
            logic [11:0] a;
            a = b + 12'(i);
            exp_q.push_back(32'h100 + {20'h0, a});
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < budget);
      check(tag, done, 1);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic settle_and_close(input string tag, input int words);
      repeat (3) @(negedge clk);
      check({tag, "_words"}, hs_count, words);
      check({tag, "_left"}, exp_q.size(), 0);
      check({tag, "_done_once"}, done_cnt, 1);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_valid"}, out_valid, 0);
   endtask

   initial begin
      logic [11:0] addr_before;
      int          n;

      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wen", ram_wEn, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic run with the consumer always ready
      start_xfer(12'h010, 13'd8, 1);
      @(negedge clk);
      check("basic_busy", busy, 1);
      check("basic_addr0", ram_addr, 12'h010);
      check("basic_lat_e0", out_valid, 0);
      @(negedge clk);
      check("basic_lat_e1", out_valid, 0);
      @(negedge clk);
      check("basic_lat_e2", out_valid, 1);
      check("basic_first", out_data, 32'h110);
      wait_done(50, "basic_done");
      check("basic_done_gap", cyc - hs_last, 1);
      check("basic_back2back", hs_last - hs_first, 7);
      settle_and_close("basic", 8);

      // Wrap across the top of the address space
      start_xfer(12'hFFE, 13'd4, 1);
      wait_done(50, "wrap_done");
      settle_and_close("wrap", 4);
      check("wrap_addr_cnt", addr_log.size(), 4);
      if (addr_log.size() == 4) begin
         check("wrap_addr0", addr_log[0], 12'hFFE);
         check("wrap_addr1", addr_log[1], 12'hFFF);
         check("wrap_addr2", addr_log[2], 12'h000);
         check("wrap_addr3", addr_log[3], 12'h001);
      end

      // Zero length: done only, nothing read
      addr_before = ram_addr;
      start_xfer(12'h555, 13'd0, 1);
      wait_done(1, "zero_done");
      check("zero_valid", out_valid, 0);
      @(negedge clk);
      check("zero_pulse_end", done, 0);
      check("zero_busy", busy, 0);
      check("zero_addr", ram_addr, addr_before);
      check("zero_done_once", done_cnt, 1);

      // Heavy backpressure
      fifo_max = 0;
      rand_ready = 1;
      start_xfer(12'h000, 13'd16, 1);
      wait_done(1000, "bp_done");
      rand_ready = 0;
      settle_and_close("bp", 16);
      check("bp_fifo_bound", fifo_max <= 4, 1);

      // Start while busy is ignored
      start_xfer(12'h040, 13'd8, 1);
      repeat (2) @(posedge clk);
      start_xfer(12'h200, 13'd5, 0);
      wait_done(50, "busy_done");
      settle_and_close("busy", 8);

      // Reset in the middle of a transfer
      start_xfer(12'h080, 13'd10, 1);
      n = 0;
      while (hs_count < 3 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("rstmid_reached", hs_count, 3);
      #1 rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rstmid_busy", busy, 0);
      check("rstmid_done", done, 0);
      check("rstmid_addr", ram_addr, 0);
      check("rstmid_valid", out_valid, 0);
      check("rstmid_data", out_data, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      hs_count = 0;
      repeat (3) @(negedge clk);
      check("rstmid_after_valid", out_valid, 0);
      check("rstmid_after_words", hs_count, 0);
      start_xfer(12'h020, 13'd2, 1);
      wait_done(50, "rstmid_new_done");
      settle_and_close("rstmid_new", 2);

      // Randomized transfers
      fifo_max = 0;
      for (int t = 0; t < 6; t++) begin
         logic [11:0] b;
         logic [12:0] len;
         b          = 12'($urandom_range(0, 4095));
         len        = 13'($urandom_range(1, 40));
         rand_ready = ($urandom_range(0, 1) == 1);
         start_xfer(b, len, 1);
         wait_done(600, "rand_done");
         rand_ready = 0;
         settle_and_close("rand", int'(len));
      end
      check("rand_fifo_bound", fifo_max <= 4, 1);

      // Full address space
      start_xfer(12'h000, 13'd4096, 1);
      wait_done(5000, "full_done");
      settle_and_close("full", 4096);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
